// File: rtl/cpu_pkg.sv
// Shared constants and types for the memory copy engine.
package cpu_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StRead  = S_READ,
    StWrite = S_WRITE,
    StDone  = S_DONE
  } state_e;

endpackage

// File: rtl/mem_addr_gen.sv
// Combinational word address generator: base + WORD_BYTES * index, modulo 2^SIZE.
module mem_addr_gen
  import cpu_pkg::*;
#(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned IDX_W = 16
) (
  input  logic [SIZE-1:0]  base_i,
  input  logic [IDX_W-1:0] index_i,
  output logic [SIZE-1:0]  addr_o
);

  logic [SIZE-1:0] offset;

  // Scale the word index to a byte offset; the add wraps silently.
  always_comb begin
    offset = SIZE'(index_i) << WORD_SHIFT;
    addr_o = base_i + offset;
  end

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy DMA helper: read a word, write it, repeat LEN times, then pulse done.
module mem_copy_engine
  import cpu_pkg::*;
#(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SIZE-1:0]  src_addr,
  input  logic [SIZE-1:0]  dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_done,
  output logic [SIZE-1:0]  checksum,
  output logic             memRead,
  output logic             memWrite,
  output logic [SIZE-1:0]  address,
  output logic [SIZE-1:0]  WriteData,
  input  logic [SIZE-1:0]  ReadData
);

  state_e           state_q, state_d;
  logic [SIZE-1:0]  src_q, src_d;
  logic [SIZE-1:0]  dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [SIZE-1:0]  data_q, data_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic [SIZE-1:0]  sum_q, sum_d;

  logic [LEN_W-1:0] words_inc;
  logic [SIZE-1:0]  src_word_addr;
  logic [SIZE-1:0]  dst_word_addr;

  mem_addr_gen #(
    .SIZE  (SIZE),
    .IDX_W (LEN_W)
  ) u_src_addr (
    .base_i  (src_q),
    .index_i (words_q),
    .addr_o  (src_word_addr)
  );

  mem_addr_gen #(
    .SIZE  (SIZE),
    .IDX_W (LEN_W)
  ) u_dst_addr (
    .base_i  (dst_q),
    .index_i (words_q),
    .addr_o  (dst_word_addr)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      words_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
      words_q <= words_d;
      sum_q   <= sum_d;
    end
  end

  // Next-state and datapath update; start is only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    data_d    = data_q;
    words_d   = words_q;
    sum_d     = sum_q;
    words_inc = words_q + LEN_W'(1);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          words_d = '0;
          sum_d   = '0;
          state_d = (len == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        data_d  = ReadData;
        sum_d   = sum_q + ReadData;
        state_d = StWrite;
      end
      StWrite: begin
        words_d = words_inc;
        state_d = (words_inc == len_q) ? StDone : StRead;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus and status outputs decoded purely from registered state.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    address   = '0;
    WriteData = '0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StRead: begin
        busy    = 1'b1;
        memRead = 1'b1;
        address = src_word_addr;
      end
      StWrite: begin
        busy      = 1'b1;
        memWrite  = 1'b1;
        address   = dst_word_addr;
        WriteData = data_q;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign words_done = words_q;
  assign checksum   = sum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine with a byte-array memory and a reference copy model.
module tb_mem_copy_engine;

  localparam int unsigned SIZE  = 32;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned MEM_BYTES = 1024;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [31:0] sum;
    logic [15:0] words;
    logic [31:0] cyc;
  } done_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [SIZE-1:0]  src_addr;
  logic [SIZE-1:0]  dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] words_done;
  logic [SIZE-1:0]  checksum;
  logic             memRead;
  logic             memWrite;
  logic [SIZE-1:0]  address;
  logic [SIZE-1:0]  WriteData;
  logic [SIZE-1:0]  ReadData;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  // Memory seen by the DUT, and the golden memory the reference model updates.
  bit [7:0] mem     [MEM_BYTES];
  bit [7:0] ref_mem [MEM_BYTES];

  int unsigned exp_rd[$];
  wr_t         exp_wr[$];
  done_t       exp_done[$];

  mem_copy_engine #(
    .SIZE  (SIZE),
    .LEN_W (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .checksum   (checksum),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .address    (address),
    .WriteData  (WriteData),
    .ReadData   (ReadData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned midx(int unsigned a);
    return a % MEM_BYTES;
  endfunction

  function automatic logic [31:0] mem_rd(bit use_ref, int unsigned a);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) begin
      if (use_ref) w[8*j +: 8] = ref_mem[midx(a + j)];
      else         w[8*j +: 8] = mem[midx(a + j)];
    end
    return w;
  endfunction

  task automatic ref_wr(int unsigned a, logic [31:0] w);
    for (int j = 0; j < 4; j++) ref_mem[midx(a + j)] = w[8*j +: 8];
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: read data presented while memRead is high, writes commit on posedge.
  always @(negedge clk) ReadData = memRead ? mem_rd(1'b0, address) : '0;

  always @(posedge clk) begin
    if (memWrite && !rst) begin
      for (int j = 0; j < 4; j++) mem[midx(address + j)] <= WriteData[8*j +: 8];
    end
  end

  // Monitor: pops expected bus traffic and completions, plus protocol checks.
  always @(negedge clk) begin
    int unsigned ra;
    wr_t         w;
    done_t       d;
    if (!rst) begin
      chk("rd_wr_exclusive", {63'd0, memRead & memWrite}, 64'd0);
      if (!busy) begin
        chk("idle_done_low", {63'd0, done}, 64'd0);
        chk("idle_mem_low", {62'd0, memRead, memWrite}, 64'd0);
      end
      if (memWrite) chk("write_only_in_write", {63'd0, busy & ~done & ~memRead}, 64'd1);
      if (memRead) begin
        chk("read_expected", {63'd0, exp_rd.size() > 0}, 64'd1);
        if (exp_rd.size() > 0) begin
          ra = exp_rd.pop_front();
          chk("rd_addr", 64'(address), 64'(ra));
        end
      end
      if (memWrite) begin
        chk("write_expected", {63'd0, exp_wr.size() > 0}, 64'd1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          chk("wr_addr", 64'(address), 64'(w.addr));
          chk("wr_data", 64'(WriteData), 64'(w.data));
        end
      end
      if (done) begin
        chk("done_expected", {63'd0, exp_done.size() > 0}, 64'd1);
        if (exp_done.size() > 0) begin
          d = exp_done.pop_front();
          chk("done_checksum", 64'(checksum), 64'(d.sum));
          chk("done_words", 64'(words_done), 64'(d.words));
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    chk("idle_reached", {63'd0, busy}, 64'd0);
  endtask

  // Issue a job and push the reference model's expected reads, writes and completion.
  task automatic run_job(int unsigned s, int unsigned d, int unsigned n);
    int unsigned sc;
    logic [31:0] sum;
    logic [31:0] w;
    for (int i = 0; i < 400 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    chk("job_issue_idle", {63'd0, busy}, 64'd0);
    src_addr = s;
    dst_addr = d;
    len      = LEN_W'(n);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sc    = cyc;
    sum   = '0;
    for (int i = 0; i < int'(n); i++) begin
      w = mem_rd(1'b1, s + 4 * i);
      exp_rd.push_back(s + 4 * i);
      exp_wr.push_back('{addr: d + 4 * i, data: w});
      ref_wr(d + 4 * i, w);
      sum += w;
    end
    exp_done.push_back('{sum: sum, words: 16'(n), cyc: sc + 2 * n});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    logic [31:0] init_words [8] = '{9, 8, 7, 6, 5, 4, 3, 8};
    rst = 1'b1;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        mem[4*i + j]     = init_words[i][8*j +: 8];
        ref_mem[4*i + j] = init_words[i][8*j +: 8];
      end
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_mem_en", {62'd0, memRead, memWrite}, 64'd0);
    chk("rst_address", 64'(address), 64'd0);
    chk("rst_wdata", 64'(WriteData), 64'd0);
    chk("rst_words", 64'(words_done), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic copy
    run_job(0, 100, 3);
    wait_idle();
    chk("basic_mem100", 64'(mem_rd(1'b0, 100)), 64'd9);
    chk("basic_mem104", 64'(mem_rd(1'b0, 104)), 64'd8);
    chk("basic_mem108", 64'(mem_rd(1'b0, 108)), 64'd7);
    chk("basic_checksum", 64'(checksum), 64'd24);
    chk("basic_words", 64'(words_done), 64'd3);

    // Zero length
    run_job(0, 400, 0);
    wait_idle();
    chk("zero_checksum", 64'(checksum), 64'd0);
    chk("zero_words", 64'(words_done), 64'd0);

    // Start pulsed mid-job is ignored
    run_job(4, 300, 5);
    repeat (3) @(posedge clk);
    #1;
    src_addr = 0;
    dst_addr = 500;
    len = 2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    chk("ignored_checksum", 64'(checksum), 64'd30);
    chk("ignored_words", 64'(words_done), 64'd5);

    // Reset during the third WRITE of an 8-word job
    src_addr = 0;
    dst_addr = 200;
    len = 8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) exp_rd.push_back(4 * i);
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back('{addr: 200 + 4 * i, data: mem_rd(1'b1, 4 * i)});
      ref_wr(200 + 4 * i, mem_rd(1'b1, 4 * i));
    end
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("midrst_mem_en", {62'd0, memRead, memWrite}, 64'd0);
    chk("midrst_address", 64'(address), 64'd0);
    chk("midrst_wdata", 64'(WriteData), 64'd0);
    chk("midrst_words", 64'(words_done), 64'd0);
    chk("midrst_checksum", 64'(checksum), 64'd0);
    chk("midrst_rd_drained", 64'(exp_rd.size()), 64'd0);
    chk("midrst_wr_drained", 64'(exp_wr.size()), 64'd0);
    chk("midrst_mem200", 64'(mem_rd(1'b0, 200)), 64'd9);
    chk("midrst_mem204", 64'(mem_rd(1'b0, 204)), 64'd8);
    chk("midrst_mem208", 64'(mem_rd(1'b0, 208)), 64'd0);
    run_job(8, 220, 2);
    wait_idle();
    chk("postrst_words", 64'(words_done), 64'd2);
    chk("postrst_checksum", 64'(checksum), 64'd13);

    // Destination address wrap
    run_job(0, 32'hFFFF_FFFC, 2);
    wait_idle();
    chk("wrap_top", 64'(mem_rd(1'b0, 32'hFFFF_FFFC)), 64'd9);
    chk("wrap_zero", 64'(mem_rd(1'b0, 0)), 64'd8);

    // Randomized jobs, including overlaps and unaligned addresses
    for (int k = 0; k < 14; k++) begin
      run_job($urandom_range(0, 40), $urandom_range(0, 160), $urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    chk("final_rd_drained", 64'(exp_rd.size()), 64'd0);
    chk("final_wr_drained", 64'(exp_wr.size()), 64'd0);
    chk("final_done_drained", 64'(exp_done.size()), 64'd0);
    mism = 0;
    for (int i = 0; i < int'(MEM_BYTES); i++) if (mem[i] != ref_mem[i]) mism++;
    chk("final_mem_image", 64'(mism), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
